// File: rtl/bidir_pin_arbiter.sv
// bidir_pin_arbiter
//   Owns one shared tri-state pad. Two local requesters take turns driving it
//   under round-robin arbitration. Every change of pad direction is padded by
//   TURN_CYC hi-Z guard cycles, and a single grant is force-released after
//   MAX_HOLD consecutive drive cycles. While nobody drives, the pad is
//   synchronized and its transitions are reported as one-cycle pulses.
//
// Ports
//   clk48    : system clock
//   rst      : synchronous reset, active-high
//   req[i]   : requester i wants the pad (held high for the whole transfer)
//   dout[i]  : level requester i wants on the pad
//   grant    : one-hot or zero, current pad owner
//   timeout  : one-cycle pulse when the owner's grant was force-released
//   pin      : shared pad, driven only while pin_oe is high
//   pin_oe   : registered output enable / direction indicator
//   pin_in   : pad level after a 2-flop synchronizer
//   rx_edge  : one-cycle pulse on each pin_in transition while listening
module bidir_pin_arbiter #(
    parameter int unsigned TURN_CYC = 4,
    parameter int unsigned MAX_HOLD = 1024
) (
    input  logic       clk48,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [1:0] dout,
    output logic [1:0] grant,
    output logic [1:0] timeout,
    inout  wire        pin,
    output logic       pin_oe,
    output logic       pin_in,
    output logic       rx_edge
);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] TURN_ON  = 2'd1;
    localparam logic [1:0] DRIVE    = 2'd2;
    localparam logic [1:0] TURN_OFF = 2'd3;

    // Terminal values of the guard and hold counters. With TURN_CYC = 0 the
    // guard counter is compared against 0, so TURN_OFF still lasts one cycle.
    localparam logic [3:0]  TURN_LAST = (TURN_CYC == 0) ? 4'd0 : 4'(TURN_CYC - 1);
    localparam logic [15:0] HOLD_LAST = 16'(MAX_HOLD - 1);

    logic [1:0]  state, state_nx;
    logic        owner, owner_nx;
    logic        last_owner, last_nx;
    logic [3:0]  turn_cnt, turn_nx;
    logic [15:0] hold_cnt, hold_nx;
    logic [1:0]  timeout_nx;
    logic [1:0]  grant_nx;
    logic        pick;
    logic        turn_done;
    logic        pin_out;
    logic        sync_a;
    logic [1:0]  idle_cnt;

    assign pin       = pin_oe ? pin_out : 1'bz;
    assign turn_done = (turn_cnt == TURN_LAST);

    // Round-robin choice: a lone requester wins, a tie goes to the requester
    // that did not drive last.
    always_comb begin
        pick = ~last_owner;
        case (req)
            2'b01:   pick = 1'b0;
            2'b10:   pick = 1'b1;
            default: pick = ~last_owner;
        endcase
    end

    always_comb begin
        state_nx   = state;
        owner_nx   = owner;
        last_nx    = last_owner;
        turn_nx    = turn_cnt;
        hold_nx    = hold_cnt;
        timeout_nx = '0;
        case (state)
            IDLE: begin
                if (|req) begin
                    owner_nx = pick;
                    turn_nx  = '0;
                    if (TURN_CYC == 0) begin
                        state_nx = DRIVE;
                        last_nx  = pick;
                        hold_nx  = '0;
                    end else begin
                        state_nx = TURN_ON;
                    end
                end
            end
            TURN_ON: begin
                if (!req[owner]) begin
                    state_nx = IDLE;
                end else if (turn_done) begin
                    state_nx = DRIVE;
                    last_nx  = owner;
                    hold_nx  = '0;
                end else begin
                    turn_nx = turn_cnt + 4'd1;
                end
            end
            DRIVE: begin
                // A normal release takes precedence over a coincident expiry.
                if (!req[owner]) begin
                    state_nx = TURN_OFF;
                    turn_nx  = '0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_nx          = TURN_OFF;
                    turn_nx           = '0;
                    timeout_nx[owner] = 1'b1;
                end else begin
                    hold_nx = hold_cnt + 16'd1;
                end
            end
            TURN_OFF: begin
                if (turn_done) begin
                    // Guard already served: a waiting request goes straight
                    // to DRIVE without another TURN_ON.
                    if (|req) begin
                        state_nx = DRIVE;
                        owner_nx = pick;
                        last_nx  = pick;
                        hold_nx  = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    turn_nx = turn_cnt + 4'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        grant_nx = '0;
        if (state_nx == DRIVE) grant_nx[owner_nx] = 1'b1;
    end

    always_ff @(posedge clk48) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= 1'b0;
            last_owner <= 1'b1;
            turn_cnt   <= '0;
            hold_cnt   <= '0;
            grant      <= '0;
            timeout    <= '0;
            pin_oe     <= 1'b0;
            pin_out    <= 1'b0;
            sync_a     <= 1'b0;
            pin_in     <= 1'b0;
            idle_cnt   <= '0;
            rx_edge    <= 1'b0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_owner <= last_nx;
            turn_cnt   <= turn_nx;
            hold_cnt   <= hold_nx;
            grant      <= grant_nx;
            timeout    <= timeout_nx;
            pin_oe     <= (state_nx == DRIVE);
            pin_out    <= (state_nx == DRIVE) ? dout[owner_nx] : 1'b0;
            sync_a     <= pin;
            pin_in     <= sync_a;
            // Counts IDLE cycles (saturating at 2) so the synchronizer has
            // flushed any level left over from reset or from our own drive.
            if (state == IDLE) begin
                if (idle_cnt != 2'd2) idle_cnt <= idle_cnt + 2'd1;
            end else begin
                idle_cnt <= '0;
            end
            rx_edge <= (state == IDLE) && (state_nx == IDLE) &&
                       (idle_cnt == 2'd2) && (sync_a != pin_in);
        end
    end

endmodule
